// File: rtl/rpsc_seq_ctrl.sv
// rpsc_seq_ctrl: RF protection chain power-up sequencer and fault latch.
// Optional macro RPSC_FIRST_FAULT_EN adds the first_fault capture output.
module rpsc_seq_ctrl #(
  parameter int DWELL_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       fault_reset,
  input  logic       g2_ok_b,
  input  logic       dr_amp_ok_b,
  input  logic       ca_ok_b,
  input  logic       anode_ok_b,
  input  logic [4:0] fault_in,
  output logic       g1_on_b,
  output logic       dr_amp_on_b,
  output logic       ca_on_b,
  output logic       anode_on_b,
  output logic [5:0] ff_latch,
  output logic       alarm_b,
  output logic [2:0] state,
  output logic       rf_ready
`ifdef RPSC_FIRST_FAULT_EN
  ,
  output logic [2:0] first_fault
`endif
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_G1    = 3'd1,
    S_DR    = 3'd2,
    S_CA    = 3'd3,
    S_ANODE = 3'd4,
    S_RUN   = 3'd5,
    S_TRIP  = 3'd6
  } state_t;
  localparam logic [CNT_W-1:0] L_DW  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TO1 = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TO  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_ff, w_ff_nxt;
  logic [3:0]       r_en_b;
  logic             r_alarm_b, r_ready, r_armed;
  logic             w_fault, w_stage_ok, w_tmo, w_run_bad, w_clr, w_go, w_adv;
  always_comb begin
    w_fault    = |fault_in;
    w_stage_ok = (r_state == S_DR) ? !dr_amp_ok_b : (r_state == S_CA) ? !ca_ok_b : !anode_ok_b;
    w_tmo      = (r_state inside {S_DR, S_CA, S_ANODE}) && !w_stage_ok && (r_cnt >= L_TO1);
    w_run_bad  = (r_state == S_RUN) && (g2_ok_b || dr_amp_ok_b || ca_ok_b || anode_ok_b);
    w_clr      = (r_state inside {S_IDLE, S_TRIP}) && fault_reset && !w_fault;
    w_ff_nxt   = w_clr ? 6'd0 : (r_ff | {w_tmo || w_run_bad, fault_in});
    w_go       = start && !stop && !g2_ok_b && (r_ff == 6'd0) && !w_fault && r_armed;
    w_adv      = (r_cnt >= L_DW) && ((r_state == S_G1) || w_stage_ok);
    w_nxt      = r_state;
    // Priority among active stages: fault/timeout, then stop, then advance
    if (r_state == S_IDLE) w_nxt = w_go ? S_G1 : S_IDLE;
    else if (r_state == S_TRIP) w_nxt = w_clr ? S_IDLE : S_TRIP;
    else if (w_fault || w_tmo || w_run_bad) w_nxt = S_TRIP;
    else if (stop) w_nxt = S_IDLE;
    else if (w_adv && r_state != S_RUN) w_nxt = state_t'(r_state + 3'd1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ff      <= '0;
      r_alarm_b <= 1'b1;
      r_en_b    <= 4'hF;
      r_ready   <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= (w_nxt != r_state) ? '0 : (r_cnt == L_TO) ? r_cnt : r_cnt + L_ONE;
      r_ff      <= w_ff_nxt;
      r_alarm_b <= ~|w_ff_nxt;
      r_en_b[0] <= !(w_nxt inside {S_G1, S_DR, S_CA, S_ANODE, S_RUN});
      r_en_b[1] <= !(w_nxt inside {S_DR, S_CA, S_ANODE, S_RUN});
      r_en_b[2] <= !(w_nxt inside {S_CA, S_ANODE, S_RUN});
      r_en_b[3] <= !(w_nxt inside {S_ANODE, S_RUN});
      r_ready   <= (w_nxt == S_RUN);
      // Start must be seen low before it can launch a new sequence
      r_armed   <= (w_go || r_state == S_TRIP) ? 1'b0 : !start ? 1'b1 : r_armed;
    end
  end
  assign g1_on_b     = r_en_b[0];
  assign dr_amp_on_b = r_en_b[1];
  assign ca_on_b     = r_en_b[2];
  assign anode_on_b  = r_en_b[3];
  assign ff_latch    = r_ff;
  assign alarm_b     = r_alarm_b;
  assign state       = r_state;
  assign rf_ready    = r_ready;
`ifdef RPSC_FIRST_FAULT_EN
  logic [5:0] w_new;
  logic [2:0] w_first_idx, r_first;
  always_comb begin
    w_new       = w_ff_nxt & ~r_ff;
    w_first_idx = 3'd0;
    for (int i = 5; i >= 0; i--) if (w_new[i]) w_first_idx = 3'(i + 1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_first <= 3'd0;
    else r_first <= w_clr ? 3'd0 : (r_first == 3'd0) ? w_first_idx : r_first;
  end
  assign first_fault = r_first;
`endif
endmodule

// File: tb/tb_rpsc_seq_ctrl.sv
// tb_rpsc_seq_ctrl: directed checks of the sequencer with DWELL=4, TIMEOUT=8.
module tb_rpsc_seq_ctrl;
  logic       clk = 1'b0;
  logic       reset, start, stop, fault_reset;
  logic       g2_ok_b, dr_amp_ok_b, ca_ok_b, anode_ok_b;
  logic [4:0] fault_in;
  logic       g1_on_b, dr_amp_on_b, ca_on_b, anode_on_b, alarm_b, rf_ready;
  logic [5:0] ff_latch;
  logic [2:0] state;
`ifdef RPSC_FIRST_FAULT_EN
  logic [2:0] first_fault;
`endif
  int checks = 0;
  int failures = 0;

  rpsc_seq_ctrl #(.DWELL_CYCLES(4), .TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .fault_reset(fault_reset),
    .g2_ok_b(g2_ok_b), .dr_amp_ok_b(dr_amp_ok_b), .ca_ok_b(ca_ok_b), .anode_ok_b(anode_ok_b),
    .fault_in(fault_in), .g1_on_b(g1_on_b), .dr_amp_on_b(dr_amp_on_b), .ca_on_b(ca_on_b),
    .anode_on_b(anode_on_b), .ff_latch(ff_latch), .alarm_b(alarm_b), .state(state),
    .rf_ready(rf_ready)
`ifdef RPSC_FIRST_FAULT_EN
    , .first_fault(first_fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; fault_reset = 1'b0; fault_in = 5'd0;
    g2_ok_b = 1'b0; dr_amp_ok_b = 1'b1; ca_ok_b = 1'b1; anode_ok_b = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Start pulse then n edges; ok inputs drop 2 cycles after each stage entry
  task automatic bring_up(input int n, input bit ca_hold);
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 7) dr_amp_ok_b = 1'b0;
      if (c == 11 && !ca_hold) ca_ok_b = 1'b0;
      if (c == 15) anode_ok_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state, g1_on_b, dr_amp_on_b, ca_on_b, anode_on_b, ff_latch, alarm_b, rf_ready} !== {3'd0, 4'hF, 6'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got st=%0d en=%b%b%b%b ff=%b alarm_b=%b rdy=%b want st=0 en=1111 ff=0 alarm_b=1 rdy=0",
               state, g1_on_b, dr_amp_on_b, ca_on_b, anode_on_b, ff_latch, alarm_b, rf_ready);
    end
  endtask

  task automatic test_nominal();
    logic [7:0] got, exp;
    int es;
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 7) dr_amp_ok_b = 1'b0;
      if (c == 11) ca_ok_b = 1'b0;
      if (c == 15) anode_ok_b = 1'b0;
      es = c < 5 ? 1 : c < 9 ? 2 : c < 13 ? 3 : c < 17 ? 4 : 5;
      got = {state, g1_on_b, dr_amp_on_b, ca_on_b, anode_on_b, rf_ready};
      exp = {3'(es), 1'b0, es < 2, es < 3, es < 4, es == 5};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL nominal_cycle%0d got {st,en,rdy}=%b want %b", c, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    reset = 1'b1;
    #1;
    checks++;
    if ({state, g1_on_b, dr_amp_on_b, ca_on_b, anode_on_b, ff_latch, rf_ready} !== {3'd0, 4'hF, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got st=%0d en=%b%b%b%b ff=%b rdy=%b want st=0 en=1111 ff=0 rdy=0",
               state, g1_on_b, dr_amp_on_b, ca_on_b, anode_on_b, ff_latch, rf_ready);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    bring_up(16, 1'b1);
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL timeout_pre got st=%0d want 3", state);
    end
    tick();
    checks++;
    if ({state, ff_latch, alarm_b, g1_on_b, dr_amp_on_b, ca_on_b, anode_on_b} !== {3'd6, 6'b100000, 1'b0, 4'hF}) begin
      failures++;
      $display("FAIL timeout_trip got st=%0d ff=%b alarm_b=%b en=%b%b%b%b want st=6 ff=100000 alarm_b=0 en=1111",
               state, ff_latch, alarm_b, g1_on_b, dr_amp_on_b, ca_on_b, anode_on_b);
    end
    fault_reset = 1'b1;
    tick();
    fault_reset = 1'b0;
    checks++;
    if ({state, ff_latch, alarm_b} !== {3'd0, 6'd0, 1'b1}) begin
      failures++;
      $display("FAIL timeout_clear got st=%0d ff=%b alarm_b=%b want st=0 ff=0 alarm_b=1", state, ff_latch, alarm_b);
    end
  endtask

  task automatic test_trip_run();
    do_reset();
    bring_up(17, 1'b0);
    checks++;
    if ({state, rf_ready} !== {3'd5, 1'b1}) begin
      failures++;
      $display("FAIL trip_run_pre got st=%0d rdy=%b want st=5 rdy=1", state, rf_ready);
    end
    start = 1'b1;
    fault_in = 5'b00100;
    tick();
    fault_in = 5'd0;
    checks++;
    if ({state, ff_latch, alarm_b, rf_ready, g1_on_b} !== {3'd6, 6'b000100, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL trip_run got st=%0d ff=%b alarm_b=%b rdy=%b g1=%b want st=6 ff=000100 alarm_b=0 rdy=0 g1=1",
               state, ff_latch, alarm_b, rf_ready, g1_on_b);
    end
    fault_in = 5'b00100;
    fault_reset = 1'b1;
    tick();
    checks++;
    if ({state, ff_latch} !== {3'd6, 6'b000100}) begin
      failures++;
      $display("FAIL reset_blocked got st=%0d ff=%b want st=6 ff=000100", state, ff_latch);
    end
    fault_in = 5'd0;
    tick();
    fault_reset = 1'b0;
    checks++;
    if ({state, ff_latch, alarm_b} !== {3'd0, 6'd0, 1'b1}) begin
      failures++;
      $display("FAIL trip_clear got st=%0d ff=%b alarm_b=%b want st=0 ff=0 alarm_b=1", state, ff_latch, alarm_b);
    end
    tick(); tick(); tick();
    checks++;
    if ({state, g1_on_b} !== {3'd0, 1'b1}) begin
      failures++;
      $display("FAIL start_held got st=%0d g1=%b want st=0 g1=1", state, g1_on_b);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({state, g1_on_b} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL start_rearm got st=%0d g1=%b want st=1 g1=0", state, g1_on_b);
    end
  endtask

  task automatic test_stop();
    do_reset();
    bring_up(10, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({state, g1_on_b, dr_amp_on_b, ca_on_b, anode_on_b, ff_latch} !== {3'd0, 4'hF, 6'd0}) begin
      failures++;
      $display("FAIL stop_in_ca got st=%0d en=%b%b%b%b ff=%b want st=0 en=1111 ff=0",
               state, g1_on_b, dr_amp_on_b, ca_on_b, anode_on_b, ff_latch);
    end
  endtask

  task automatic test_fault_and_stop();
    do_reset();
    bring_up(6, 1'b0);
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL simul_pre got st=%0d want 2", state);
    end
    stop = 1'b1;
    fault_in = 5'b00001;
    tick();
    stop = 1'b0;
    fault_in = 5'd0;
    checks++;
    if ({state, ff_latch, alarm_b} !== {3'd6, 6'b000001, 1'b0}) begin
      failures++;
      $display("FAIL simul_fault_stop got st=%0d ff=%b alarm_b=%b want st=6 ff=000001 alarm_b=0", state, ff_latch, alarm_b);
    end
  endtask

  task automatic test_idle_fault();
    do_reset();
    start = 1'b1;
    fault_in = 5'b10001;
    tick();
    fault_in = 5'd0;
    checks++;
    if ({state, ff_latch, alarm_b} !== {3'd0, 6'b010001, 1'b0}) begin
      failures++;
      $display("FAIL idle_fault got st=%0d ff=%b alarm_b=%b want st=0 ff=010001 alarm_b=0", state, ff_latch, alarm_b);
    end
`ifdef RPSC_FIRST_FAULT_EN
    checks++;
    if (first_fault !== 3'd1) begin
      failures++;
      $display("FAIL first_fault got %0d want 1", first_fault);
    end
`endif
    tick();
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL idle_fault_blocks_start got st=%0d want 0", state);
    end
    start = 1'b0;
    fault_reset = 1'b1;
    tick();
    fault_reset = 1'b0;
    checks++;
    if ({state, ff_latch, alarm_b} !== {3'd0, 6'd0, 1'b1}) begin
      failures++;
      $display("FAIL idle_clear got st=%0d ff=%b alarm_b=%b want st=0 ff=0 alarm_b=1", state, ff_latch, alarm_b);
    end
`ifdef RPSC_FIRST_FAULT_EN
    checks++;
    if (first_fault !== 3'd0) begin
      failures++;
      $display("FAIL first_fault_clear got %0d want 0", first_fault);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reset_mid_run();
    test_timeout();
    test_trip_run();
    test_stop();
    test_fault_and_stop();
    test_idle_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
